// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bus: decode flags, later-stage events and pipeline controls.
// The stall_cycles signal exists only when HAZARD_STALL_CNT_EN is defined.
interface pipeline_hazard_controller_if #(
    parameter int unsigned REG_ADDR_W = 4
`ifdef HAZARD_STALL_CNT_EN
   ,parameter int unsigned STALL_CNT_W = 16
`endif
);
    logic                  id_halt;
    logic                  id_return;
    logic                  id_stall_fetch;
    logic                  id_illegal;
    logic [1:0]            id_src_ren;
    logic [REG_ADDR_W-1:0] id_src_a;
    logic [REG_ADDR_W-1:0] id_src_b;
    logic                  ex_is_load;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  ex_branch_taken;
    logic                  mem_ret_valid;
    logic                  irq_req;
    logic                  pc_en;
    logic                  if_id_en;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  exc_req;
    logic [1:0]            exc_code;
    logic                  halted;
`ifdef HAZARD_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cycles;
`endif

    modport master (
        output id_halt, id_return, id_stall_fetch, id_illegal, id_src_ren,
               id_src_a, id_src_b, ex_is_load, ex_dest, ex_branch_taken,
               mem_ret_valid, irq_req,
        input
`ifdef HAZARD_STALL_CNT_EN
               stall_cycles,
`endif
               pc_en, if_id_en, if_id_flush, id_ex_flush, exc_req, exc_code, halted
    );

    modport slave (
        input  id_halt, id_return, id_stall_fetch, id_illegal, id_src_ren,
               id_src_a, id_src_b, ex_is_load, ex_dest, ex_branch_taken,
               mem_ret_valid, irq_req,
        output
`ifdef HAZARD_STALL_CNT_EN
               stall_cycles,
`endif
               pc_en, if_id_en, if_id_flush, id_ex_flush, exc_req, exc_code, halted
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// 5-stage pipeline sequencer: RUN / RET_WAIT / HALTED with prioritised hazard handling.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module pipeline_hazard_controller #(
    parameter int unsigned REG_ADDR_W  = 4,
    parameter int unsigned RET_TIMEOUT = 15
`ifdef HAZARD_STALL_CNT_EN
   ,parameter int unsigned STALL_CNT_W = 16
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pipeline_hazard_controller_if.slave   hz
);
    localparam int unsigned RetClog = $clog2(RET_TIMEOUT + 1);
    localparam int unsigned RetW    = (RetClog > 4) ? RetClog : 4;

    typedef enum logic [1:0] {ST_RUN, ST_RET_WAIT, ST_HALTED} state_e;

    state_e            state_q, state_d;
    logic [RetW-1:0]   ret_cnt_q, ret_cnt_d;
    logic              exc_req_q, exc_req_d;
    logic [1:0]        exc_code_q, exc_code_d;
    logic              halted_q;
    logic              pc_en, if_id_en, if_id_flush, id_ex_flush;
    logic              load_use, ret_timeout;
    logic [REG_ADDR_W-1:0] src_a, src_b, ex_dest;

    assign src_a   = hz.id_src_a;
    assign src_b   = hz.id_src_b;
    assign ex_dest = hz.ex_dest;

    assign load_use = hz.ex_is_load &&
                      ((hz.id_src_ren[0] && (src_a == ex_dest)) ||
                       (hz.id_src_ren[1] && (src_b == ex_dest)));
    assign ret_timeout = (ret_cnt_q == RetW'(RET_TIMEOUT));

    always_comb begin
        state_d     = state_q;
        ret_cnt_d   = ret_cnt_q;
        exc_req_d   = 1'b0;
        exc_code_d  = exc_code_q;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (hz.ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (hz.id_illegal) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    exc_req_d   = 1'b1;
                    exc_code_d  = 2'b01;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (hz.id_halt) begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    state_d  = ST_HALTED;
                end else if (hz.id_return) begin
                    pc_en       = 1'b0;
                    if_id_flush = 1'b1;
                    ret_cnt_d   = '0;
                    state_d     = ST_RET_WAIT;
                end else if (hz.id_stall_fetch) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            ST_RET_WAIT: begin
                // Branches in EX are younger than the return and are ignored here.
                pc_en       = 1'b0;
                if_id_flush = 1'b1;
                if (ret_cnt_q != '1) ret_cnt_d = ret_cnt_q + 1'b1;
                if (hz.mem_ret_valid) begin
                    pc_en   = 1'b1;
                    state_d = ST_RUN;
                end else if (ret_timeout) begin
                    state_d    = ST_RUN;
                    exc_req_d  = 1'b1;
                    exc_code_d = 2'b10;
                end
            end
            ST_HALTED: begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
                if (hz.irq_req) begin
                    if_id_flush = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            ret_cnt_q  <= '0;
            exc_req_q  <= 1'b0;
            exc_code_q <= 2'b00;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_cnt_q  <= ret_cnt_d;
            exc_req_q  <= exc_req_d;
            exc_code_q <= exc_code_d;
            halted_q   <= (state_d == ST_HALTED);
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!pc_en && (state_q != ST_HALTED) && (stall_q != '1)) stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign hz.stall_cycles = stall_q;
`endif

    assign hz.pc_en       = pc_en;
    assign hz.if_id_en    = if_id_en;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_ex_flush = id_ex_flush;
    assign hz.exc_req     = exc_req_q;
    assign hz.exc_code    = exc_code_q;
    assign hz.halted      = halted_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Table-driven and sequence bench for pipeline_hazard_controller with a scoreboard queue.
module tb_pipeline_hazard_controller;
    logic clk;
    logic rst_n;

    pipeline_hazard_controller_if #(.REG_ADDR_W(4)) hz ();

    pipeline_hazard_controller #(.REG_ADDR_W(4), .RET_TIMEOUT(15)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       br, ill, halt, ret, stf, ld;
        logic [1:0] ren;
        logic [3:0] a, b, d;
        logic       rv, irq;
        logic [3:0] eo;      // {pc_en, if_id_en, if_id_flush, id_ex_flush}
        logic       e_exc;
        logic [1:0] e_code;
        logic       e_halted;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t sbq[$];
    vec_t tbl[14];
    logic prev_halted = 1'b0;
    int   exp_stall = 0;

    function automatic vec_t mk(input logic br, ill, halt, ret, stf, ld,
                                input logic [1:0] ren, input logic [3:0] a, b, d,
                                input logic [3:0] eo, input logic e_exc,
                                input logic [1:0] e_code, input logic e_halted);
        vec_t v;
        v.br = br; v.ill = ill; v.halt = halt; v.ret = ret; v.stf = stf; v.ld = ld;
        v.ren = ren; v.a = a; v.b = b; v.d = d; v.rv = 1'b0; v.irq = 1'b0;
        v.eo = eo; v.e_exc = e_exc; v.e_code = e_code; v.e_halted = e_halted;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        hz.ex_branch_taken = v.br;
        hz.id_illegal      = v.ill;
        hz.id_halt         = v.halt;
        hz.id_return       = v.ret;
        hz.id_stall_fetch  = v.stf;
        hz.ex_is_load      = v.ld;
        hz.id_src_ren      = v.ren;
        hz.id_src_a        = v.a;
        hz.id_src_b        = v.b;
        hz.ex_dest         = v.d;
        hz.mem_ret_valid   = v.rv;
        hz.irq_req         = v.irq;
    endtask

    task automatic step(input string tag, input vec_t v);
        vec_t e;
        @(negedge clk);
        drive(v);
        sbq.push_back(v);
        #1;
        e = sbq.pop_front();
        chk({tag, " pc_en"},       hz.pc_en,       e.eo[3]);
        chk({tag, " if_id_en"},    hz.if_id_en,    e.eo[2]);
        chk({tag, " if_id_flush"}, hz.if_id_flush, e.eo[1]);
        chk({tag, " id_ex_flush"}, hz.id_ex_flush, e.eo[0]);
        if (!e.eo[3] && !prev_halted) exp_stall++;
        prev_halted = e.e_halted;
        @(posedge clk);
        #1;
        chk({tag, " exc_req"}, hz.exc_req, e.e_exc);
        if (e.e_exc) chk({tag, " exc_code"}, hz.exc_code, e.e_code);
        chk({tag, " halted"}, hz.halted, e.e_halted);
`ifdef HAZARD_STALL_CNT_EN
        chk({tag, " stall_cycles"}, hz.stall_cycles, exp_stall);
`endif
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " pc_en"},       hz.pc_en,       1);
        chk({tag, " if_id_en"},    hz.if_id_en,    1);
        chk({tag, " if_id_flush"}, hz.if_id_flush, 0);
        chk({tag, " id_ex_flush"}, hz.id_ex_flush, 0);
        chk({tag, " exc_req"},     hz.exc_req,     0);
        chk({tag, " exc_code"},    hz.exc_code,    0);
        chk({tag, " halted"},      hz.halted,      0);
`ifdef HAZARD_STALL_CNT_EN
        chk({tag, " stall_cycles"}, hz.stall_cycles, 0);
`endif
    endtask

    // Asserts reset between clock edges so the check proves the reset is asynchronous.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        drive(mk(0,0,0,0,0,0,2'b00,0,0,0,4'b1100,0,2'b00,0));
        #1;
        check_reset_values(tag);
        @(negedge clk);
        rst_n = 1'b1;
        exp_stall = 0;
        prev_halted = 1'b0;
        sbq.delete();
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        drive(mk(0,0,0,0,0,0,2'b00,0,0,0,4'b1100,0,2'b00,0));
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        //            br ill hlt ret stf ld  ren    a  b  d  eo      exc code  hlt
        tbl[0]  = mk(0, 0,  0,  0,  0,  0, 2'b00, 0, 0, 0, 4'b1100, 0, 2'b00, 0);
        tbl[1]  = mk(0, 0,  0,  0,  0,  1, 2'b01, 3, 0, 3, 4'b0001, 0, 2'b00, 0);
        tbl[2]  = mk(0, 0,  0,  0,  0,  1, 2'b10, 3, 5, 3, 4'b1100, 0, 2'b00, 0);
        tbl[3]  = mk(0, 0,  0,  0,  0,  1, 2'b10, 7, 3, 3, 4'b0001, 0, 2'b00, 0);
        tbl[4]  = mk(0, 0,  0,  0,  0,  0, 2'b11, 3, 3, 3, 4'b1100, 0, 2'b00, 0);
        tbl[5]  = mk(0, 0,  0,  0,  0,  1, 2'b01, 4, 3, 3, 4'b1100, 0, 2'b00, 0);
        tbl[6]  = mk(1, 1,  1,  0,  0,  0, 2'b00, 0, 0, 0, 4'b1111, 0, 2'b00, 0);
        tbl[7]  = mk(0, 1,  0,  0,  0,  0, 2'b00, 0, 0, 0, 4'b1111, 1, 2'b01, 0);
        tbl[8]  = mk(0, 0,  0,  0,  0,  0, 2'b00, 0, 0, 0, 4'b1100, 0, 2'b00, 0);
        tbl[9]  = mk(1, 0,  0,  0,  0,  1, 2'b01, 2, 0, 2, 4'b1111, 0, 2'b00, 0);
        tbl[10] = mk(0, 1,  0,  0,  0,  1, 2'b01, 2, 0, 2, 4'b1111, 1, 2'b01, 0);
        tbl[11] = mk(0, 0,  0,  0,  1,  0, 2'b00, 0, 0, 0, 4'b0001, 0, 2'b00, 0);
        tbl[12] = mk(1, 0,  0,  1,  1,  0, 2'b00, 0, 0, 0, 4'b1111, 0, 2'b00, 0);
        tbl[13] = mk(0, 0,  0,  0,  0,  0, 2'b00, 0, 0, 0, 4'b1100, 0, 2'b00, 0);
        for (int i = 0; i < 14; i++) step($sformatf("tbl%0d", i), tbl[i]);

        // Return resolved on the fourth wait cycle; a branch mid-wait is ignored.
        step("ret entry", mk(0,0,0,1,0,0,2'b00,0,0,0,4'b0110,0,2'b00,0));
        step("ret w1",    mk(0,0,0,0,0,0,2'b00,0,0,0,4'b0110,0,2'b00,0));
        step("ret w2",    mk(1,0,0,0,0,0,2'b00,0,0,0,4'b0110,0,2'b00,0));
        step("ret w3",    mk(0,0,0,0,0,0,2'b00,0,0,0,4'b0110,0,2'b00,0));
        v = mk(0,0,0,0,0,0,2'b00,0,0,0,4'b1110,0,2'b00,0);
        v.rv = 1'b1;
        step("ret valid", v);
        step("ret after", mk(0,0,0,0,0,0,2'b00,0,0,0,4'b1100,0,2'b00,0));

        // Timeout: exception leaves on the wait cycle where ret_cnt reaches 15.
        step("tmo entry", mk(0,0,0,1,0,0,2'b00,0,0,0,4'b0110,0,2'b00,0));
        for (int i = 0; i < 16; i++)
            step($sformatf("tmo w%0d", i),
                 mk(0,0,0,0,0,0,2'b00,0,0,0,4'b0110,(i == 15),2'b10,0));
        step("tmo after", mk(0,0,0,0,0,0,2'b00,0,0,0,4'b1100,0,2'b00,0));

        // Return data arriving in the timeout cycle wins over the exception.
        step("race entry", mk(0,0,0,1,0,0,2'b00,0,0,0,4'b0110,0,2'b00,0));
        for (int i = 0; i < 15; i++)
            step($sformatf("race w%0d", i), mk(0,0,0,0,0,0,2'b00,0,0,0,4'b0110,0,2'b00,0));
        v = mk(0,0,0,0,0,0,2'b00,0,0,0,4'b1110,0,2'b00,0);
        v.rv = 1'b1;
        step("race valid", v);
        step("race after", mk(0,0,0,0,0,0,2'b00,0,0,0,4'b1100,0,2'b00,0));

        // Reset mid-RET_WAIT and mid-HALTED.
        step("rw entry", mk(0,0,0,1,0,0,2'b00,0,0,0,4'b0110,0,2'b00,0));
        step("rw w1",    mk(0,0,0,0,0,0,2'b00,0,0,0,4'b0110,0,2'b00,0));
        async_reset("rst retwait");
        step("rh halt", mk(0,0,1,0,0,0,2'b00,0,0,0,4'b0000,0,2'b00,1));
        step("rh idle", mk(0,0,0,0,0,0,2'b00,0,0,0,4'b0001,0,2'b00,1));
        async_reset("rst halted");

        // Halt, ten halted cycles including the wake cycle, then resume.
        step("halt entry", mk(0,0,1,0,0,0,2'b00,0,0,0,4'b0000,0,2'b00,1));
        for (int i = 0; i < 9; i++)
            step($sformatf("halted%0d", i),
                 mk(0,(i == 4),0,0,0,0,2'b00,0,0,0,4'b0001,0,2'b00,1));
        v = mk(0,0,0,0,0,0,2'b00,0,0,0,4'b0011,0,2'b00,0);
        v.irq = 1'b1;
        step("wake", v);
        step("wake after", mk(0,0,0,0,0,0,2'b00,0,0,0,4'b1100,0,2'b00,0));
`ifdef HAZARD_STALL_CNT_EN
        chk("halt stall count", hz.stall_cycles, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
